// File: rtl/start_stop_cmd_gen_pkg.sv
// Shared types and default parameters for the start/stop command front end.
package start_stop_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/start_stop_cmd_gen_if.sv
// Button inputs and command/status outputs of the start/stop command generator.
interface start_stop_cmd_gen_if;

  logic start_btn;
  logic stop_btn;
  logic start;
  logic stop;
  logic start_db;
  logic stop_db;
  logic run;

  // master drives the raw buttons and observes the conditioned outputs
  modport master (
    output start_btn, stop_btn,
    input  start, stop, start_db, stop_db, run
  );

  modport slave (
    input  start_btn, stop_btn,
    output start, stop, start_db, stop_db, run
  );

endinterface

// File: rtl/start_stop_cmd_gen_btn_conditioner.sv
// One button channel: synchroniser chain, debounce counter and rising-edge detect.
module btn_conditioner
  import start_stop_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic x_db,
  output logic rise_x
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   db_dly_q, db_dly_d;
  logic                   sync_x;

  assign sync_x = sync_q[SYNC_STAGES-1];

  // Next-state: shift chain, debounce count (any reversion discards progress), edge delay
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], btn};
    cnt_d    = '0;
    db_d     = db_q;
    db_dly_d = db_q;
    if (sync_x == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
    end
  end

  assign x_db   = db_q;
  assign rise_x = db_q & ~db_dly_q;

endmodule

// File: rtl/start_stop_cmd_gen.sv
// Conditions two raw buttons into single-cycle start/stop commands, tracking the
// downstream enable so redundant commands are never issued; stop wins ties.
module start_stop_cmd_gen
  import start_stop_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  start_stop_cmd_gen_if.slave   bus
);

  logic start_db_s, stop_db_s;
  logic rise_start, rise_stop;

  btn_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_start_cond (
    .clk    (clk),
    .reset  (reset),
    .btn    (bus.start_btn),
    .x_db   (start_db_s),
    .rise_x (rise_start)
  );

  btn_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_stop_cond (
    .clk    (clk),
    .reset  (reset),
    .btn    (bus.stop_btn),
    .x_db   (stop_db_s),
    .rise_x (rise_stop)
  );

  run_state_t state_q, state_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;

  // Run FSM next state and command pulses
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_start && !rise_stop) begin
          state_d = RUNNING;
          start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUNNING: begin
        if (rise_stop) begin
          state_d = IDLE;
          stop_d  = 1'b1;
        end else begin
          state_d = RUNNING;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered command outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.start    = start_q;
  assign bus.stop     = stop_q;
  assign bus.start_db = start_db_s;
  assign bus.stop_db  = stop_db_s;
  assign bus.run      = (state_q == RUNNING);

endmodule

// File: tb/tb_start_stop_cmd_gen.sv
// Directed bench for start_stop_cmd_gen with default SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_start_stop_cmd_gen;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  start_stop_cmd_gen_if bus_if ();

  start_stop_cmd_gen #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int req);
    n_checks = n_checks + 1;
    if (act != req) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, act, req);
    end
  endtask

  // one rising edge, then land on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Steps n edges (edge 0 is the first one), recording pulse counts and first-pulse edge index
  task automatic watch(input int n, output int first_start, output int first_stop,
                       output int n_start, output int n_stop, output int n_both);
    first_start = -1;
    first_stop  = -1;
    n_start     = 0;
    n_stop      = 0;
    n_both      = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (bus_if.start) begin
        n_start = n_start + 1;
        if (first_start < 0) first_start = k;
      end
      if (bus_if.stop) begin
        n_stop = n_stop + 1;
        if (first_stop < 0) first_stop = k;
      end
      if (bus_if.start && bus_if.stop) n_both = n_both + 1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"},    int'(bus_if.start),    0);
    chk({tag, "_stop"},     int'(bus_if.stop),     0);
    chk({tag, "_start_db"}, int'(bus_if.start_db), 0);
    chk({tag, "_stop_db"},  int'(bus_if.stop_db),  0);
    chk({tag, "_run"},      int'(bus_if.run),      0);
  endtask

  initial begin
    int fs, fp, ns, np, nb;
    int db_ok;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus_if.start_btn = 1'b0;
    bus_if.stop_btn  = 1'b0;
    step();
    step();
    check_all_zero("rst");

    // T1: held start press, exact latency
    reset = 1'b0;
    bus_if.start_btn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("t1_start_db_e%0d", k), int'(bus_if.start_db), (k >= 5) ? 1 : 0);
      chk($sformatf("t1_start_e%0d", k),    int'(bus_if.start),    (k == 6) ? 1 : 0);
      chk($sformatf("t1_run_e%0d", k),      int'(bus_if.run),      (k >= 6) ? 1 : 0);
      chk($sformatf("t1_stop_e%0d", k),     int'(bus_if.stop),     0);
    end

    // T2: bounce with 3-cycle levels never changes start_db
    db_ok = 1;
    for (int p = 0; p < 5; p++) begin
      bus_if.start_btn = (p % 2 == 0) ? 1'b1 : 1'b0;
      for (int c = 0; c < 3; c++) begin
        step();
        if (bus_if.start_db !== 1'b1 || bus_if.start || bus_if.stop) db_ok = 0;
      end
    end
    chk("t2_bounce_stable", db_ok, 1);
    watch(8, fs, fp, ns, np, nb);
    chk("t2_start_pulses", ns, 0);
    chk("t2_stop_pulses",  np, 0);
    chk("t2_run",          int'(bus_if.run), 1);

    // T3: simultaneous press while running, stop wins
    bus_if.start_btn = 1'b0;
    watch(10, fs, fp, ns, np, nb);
    chk("t3_release_start_db", int'(bus_if.start_db), 0);
    chk("t3_release_pulses",   ns + np, 0);
    bus_if.start_btn = 1'b1;
    bus_if.stop_btn  = 1'b1;
    watch(10, fs, fp, ns, np, nb);
    chk("t3_stop_edge",   fp, 6);
    chk("t3_stop_count",  np, 1);
    chk("t3_start_count", ns, 0);
    chk("t3_run",         int'(bus_if.run), 0);
    chk("t3_both_high",   nb, 0);

    // T5: stop press while idle is ignored, then a start press works
    bus_if.start_btn = 1'b0;
    bus_if.stop_btn  = 1'b0;
    watch(10, fs, fp, ns, np, nb);
    chk("t5_idle_settle", ns + np, 0);
    bus_if.stop_btn = 1'b1;
    watch(10, fs, fp, ns, np, nb);
    chk("t5_stop_db",     int'(bus_if.stop_db), 1);
    chk("t5_stop_count",  np, 0);
    chk("t5_run",         int'(bus_if.run), 0);
    bus_if.stop_btn = 1'b0;
    watch(10, fs, fp, ns, np, nb);
    chk("t5_stop_db_low", int'(bus_if.stop_db), 0);
    bus_if.start_btn = 1'b1;
    watch(10, fs, fp, ns, np, nb);
    chk("t5_start_edge",  fs, 6);
    chk("t5_start_count", ns, 1);
    chk("t5_run_after",   int'(bus_if.run), 1);

    // T4: re-press while running is suppressed, then stop works
    bus_if.start_btn = 1'b0;
    watch(8, fs, fp, ns, np, nb);
    chk("t4_release_db", int'(bus_if.start_db), 0);
    bus_if.start_btn = 1'b1;
    watch(8, fs, fp, ns, np, nb);
    chk("t4_repress_db",     int'(bus_if.start_db), 1);
    chk("t4_repress_starts", ns, 0);
    chk("t4_run_kept",       int'(bus_if.run), 1);
    bus_if.stop_btn = 1'b1;
    watch(10, fs, fp, ns, np, nb);
    chk("t4_stop_edge",  fp, 6);
    chk("t4_stop_count", np, 1);
    chk("t4_run",        int'(bus_if.run), 0);

    // T6: reset mid-debounce with button held
    bus_if.start_btn = 1'b0;
    bus_if.stop_btn  = 1'b0;
    watch(10, fs, fp, ns, np, nb);
    chk("t6_settle", int'(bus_if.start_db) + int'(bus_if.stop_db), 0);
    bus_if.start_btn = 1'b1;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    check_all_zero("t6_rst_async");
    step();
    step();
    check_all_zero("t6_rst_held");
    reset = 1'b0;
    watch(10, fs, fp, ns, np, nb);
    chk("t6_start_edge",  fs, 6);
    chk("t6_start_count", ns, 1);
    chk("t6_stop_count",  np, 0);
    chk("t6_run",         int'(bus_if.run), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
